// File: rtl/apb_event_sink.sv
// apb_event_sink: APB3 completer terminating event-notification writes.
// Three windows (0xABBA/0xBAFF/0xCAFE in paddr[31:16]), each with a
// saturating event counter, a captured pending count and a strobe.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   apb_psel_i ..       APB3 request (psel, penable, paddr, pwrite, pwdata)
//   apb_pready_o ..     APB3 response (pready, prdata, pslverr)
//   event_x_o           one-cycle strobe per accepted event write
//   pending_x_o         last pwdata captured by an event write
//
// Offsets: 0x0 write = event, read = counter;
//          0x4 write = clear counter, read = pending.
// Anything else answers with pslverr and has no effect.
module apb_event_sink #(
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        apb_psel_i,
  input  logic        apb_penable_i,
  input  logic [31:0] apb_paddr_i,
  input  logic        apb_pwrite_i,
  input  logic [31:0] apb_pwdata_i,
  output logic        apb_pready_o,
  output logic [31:0] apb_prdata_o,
  output logic        apb_pslverr_o,
  output logic        event_a_o,
  output logic        event_b_o,
  output logic        event_c_o,
  output logic [31:0] pending_a_o,
  output logic [31:0] pending_b_o,
  output logic [31:0] pending_c_o
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t           state;
  logic [3:0]       wait_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             write_q;
  logic [CNT_W-1:0] cnt [3];
  logic [31:0]      pend [3];
  logic [2:0]       ev_q;

  logic [2:0]  sel;
  logic        off_evt;
  logic        off_clr;
  logic        hit;
  logic        done;
  logic        commit;
  logic [2:0]  evt_wr;
  logic [2:0]  clr_wr;
  logic [31:0] rd_mux;

  // Decode works purely on the latched request; live bus
  // inputs are ignored once the access phase has begun.
  assign sel[0]  = addr_q[31:16] == 16'hABBA;
  assign sel[1]  = addr_q[31:16] == 16'hBAFF;
  assign sel[2]  = addr_q[31:16] == 16'hCAFE;
  assign off_evt = addr_q[15:0] == 16'h0000;
  assign off_clr = addr_q[15:0] == 16'h0004;
  assign hit     = (|sel) & (off_evt | off_clr);

  assign apb_pready_o = (state == ACCESS)
                      & (wait_q == 4'd0);

  assign done   = apb_psel_i & apb_penable_i
                & apb_pready_o;
  assign commit = done & write_q & hit;
  assign evt_wr = sel & {3{commit & off_evt}};
  assign clr_wr = sel & {3{commit & off_clr}};

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel[0]: rd_mux = off_evt ? 32'(cnt[0])
                               : pend[0];
      sel[1]: rd_mux = off_evt ? 32'(cnt[1])
                               : pend[1];
      sel[2]: rd_mux = off_evt ? 32'(cnt[2])
                               : pend[2];
      default: rd_mux = '0;
    endcase
  end

  assign apb_prdata_o  = (apb_pready_o & hit)
                       ? rd_mux : 32'd0;
  assign apb_pslverr_o = apb_pready_o & ~hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      ev_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i]  <= '0;
        pend[i] <= '0;
      end
    end else begin
      ev_q <= evt_wr;
      for (int i = 0; i < 3; i++) begin
        if (evt_wr[i]) begin
          cnt[i]  <= sat_inc(cnt[i]);
          pend[i] <= wdata_q;
        end else if (clr_wr[i]) begin
          cnt[i] <= '0;
        end
      end
      unique case (state)
        IDLE: begin
          if (apb_psel_i && !apb_penable_i) begin
            addr_q  <= apb_paddr_i;
            write_q <= apb_pwrite_i;
            wdata_q <= apb_pwdata_i;
            wait_q  <= WAIT_LD;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // Dropping psel abandons the transfer without effect.
          if (!apb_psel_i) begin
            state <= IDLE;
          end else if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else if (apb_penable_i) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign event_a_o   = ev_q[0];
  assign event_b_o   = ev_q[1];
  assign event_c_o   = ev_q[2];
  assign pending_a_o = pend[0];
  assign pending_b_o = pend[1];
  assign pending_c_o = pend[2];

endmodule

// File: doc/apb_event_sink.md
Name: apb_event_sink

Overview:
- APB3 completer that terminates the event-notification writes issued by the event-to-APB initiator.
- Decodes the three event windows (0xABBA_xxxx, 0xBAFF_xxxx, 0xCAFE_xxxx).
- Per channel: counts received events, captures the initiator's reported pending count (PWDATA), and pulses a per-channel strobe.
- Supports readback, counter clear, programmable wait states and PSLVERR on unmapped accesses; sits on the peripheral side of the event APB segment.

Parameters:
- WAIT_CYCLES, 0, number of access-phase cycles PREADY is held low before completion (0..15).
- CNT_W, 16, width of each per-channel event counter (1..32).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- apb_psel_i  input  1  APB select.
- apb_penable_i  input  1  APB enable (access phase).
- apb_paddr_i  input  32  APB address.
- apb_pwrite_i  input  1  1 = write, 0 = read.
- apb_pwdata_i  input  32  write data (initiator's pending count).
- apb_pready_o  output  1  transfer-complete.
- apb_prdata_o  output  32  read data, valid only with pready on reads.
- apb_pslverr_o  output  1  error response, valid only with pready.
- event_a_o  output  1  one-cycle strobe per accepted event A write.
- event_b_o  output  1  one-cycle strobe per accepted event B write.
- event_c_o  output  1  one-cycle strobe per accepted event C write.
- pending_a_o  output  32  last PWDATA captured on an event A write.
- pending_b_o  output  32  last PWDATA captured on an event B write.
- pending_c_o  output  32  last PWDATA captured on an event C write.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, wait counter 0, all counters 0, all pending_x_o 0. Outputs pready/prdata/pslverr/event_x 0. Reset mid-transfer aborts it with no commit.

Address map:
- Channel select by paddr[31:16]: ABBA=A, BAFF=B, CAFE=C.
- Offset paddr[15:0]:
  - 0x0000 write = event: counter +1, pending_x <= pwdata, strobe.
  - 0x0000 read = zero-extended counter.
  - 0x0004 write = clear counter (pending_x untouched, no strobe).
  - 0x0004 read = pending_x.
- Any other channel or offset: PSLVERR=1, no state change, prdata=0.

FSM states IDLE, ACCESS:
- IDLE: on psel=1 & penable=0, latch addr/write/wdata, load wait counter with WAIT_CYCLES, go to ACCESS. Anything else: stay.
- ACCESS:
  - psel=0: protocol abort, go to IDLE with no commit and no pready.
  - Else if wait counter != 0: decrement it.
  - pready_o = (state==ACCESS) & (wait counter==0), driven from registers only.
  - Completion edge is psel & penable & pready: commit the write effect, go to IDLE.
- Latency: with setup in cycle T0, pready is high in cycle T1+WAIT_CYCLES. Back-to-back setup in the cycle after completion is accepted (no idle bubble required).
- prdata_o and pslverr_o: combinational from latched address while pready=1, otherwise 0.
- Strobes: event_x_o high exactly the cycle after the completion edge of an event write, for 1 cycle; pending_x_o updates on that same edge.
- Counter arithmetic: saturates at 2^CNT_W-1 (no wrap). Saturated writes still strobe and capture pwdata.
- Read of a counter in the same transfer as an increment is impossible (one transfer at a time); reads return the pre-edge value.
- Latched pwrite/paddr/pwdata govern the transfer; changes to the inputs during ACCESS are ignored.
- pwdata captured in full 32 bits; no byte strobes.

Test Plan:
- Reset, WAIT_CYCLES=0: write 0xABBA_0000 data 5 → pready in T1; pslverr=0; event_a_o pulses in T2; pending_a_o=5. Read 0xABBA_0000 → prdata=1.
- Three back-to-back writes A, B, C with data 2, 1, 0 → each completes in 2 cycles. Strobes a, b, c in successive transfers. Reads return counters 1/1/1 and pending 2/1/0.
- WAIT_CYCLES=3: write 0xCAFE_0000 → pready low T1–T3, high T4. Single strobe; counter_c=1.
- Write 0x1234_0000 and read 0xABBA_0008 → pslverr=1 with pready; prdata=0; no strobe; all counters unchanged.
- CNT_W=4: 17 writes to 0xBAFF_0000 → counter_b=15, 17 strobes. Write 0xBAFF_0004 → counter_b=0, pending_b_o unchanged.
- WAIT_CYCLES=3: drop psel in T2 of a write → no pready, no commit, FSM IDLE. Assert reset low during ACCESS → all outputs 0 next cycle.
